// File: rtl/bispectrum_accum_engine.sv
// Segment-averaging bispectrum engine: B[k] = sum_seg F1*F2*conj(F3).
// Three-stage accumulate pipeline (F1*F2, *conj(F3), RAM read-modify-write)
// feeding per-bin accumulators. After the last segment the bins are
// drained and streamed out scaled and saturated, one bin per handshake.
module bispectrum_accum_engine #(
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 14,
  parameter  int ACC_W  = 40,
  parameter  int NBIN   = 64,
  parameter  int SEG_W  = 8,
  localparam int BIN_W  = $clog2(NBIN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SEG_W-1:0]         num_seg,
  input  logic [5:0]               out_shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] f1_r,
  input  logic signed [DATA_W-1:0] f1_i,
  input  logic signed [DATA_W-1:0] f2_r,
  input  logic signed [DATA_W-1:0] f2_i,
  input  logic signed [DATA_W-1:0] f3_r,
  input  logic signed [DATA_W-1:0] f3_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic [BIN_W-1:0]         out_bin,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int STAGES = 2;
  // Product width: two full DATA_W products summed plus the rounding term.
  localparam int PW = 2*DATA_W + 2;
  // Output scaling needs room for a rounding term up to 2^62.
  localparam int OW = ((ACC_W > 64) ? ACC_W : 64) + 1;

  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  AMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     RND  = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
  } cplx_t;

  typedef struct packed {
    cplx_t            t;
    cplx_t            f3;
    logic [BIN_W-1:0] bin;
    logic             first;
  } s1_t;

  typedef struct packed {
    logic [ACC_W-1:0] pr;
    logic [ACC_W-1:0] pi;
    logic [BIN_W-1:0] bin;
    logic             first;
  } s2_t;

  function automatic logic signed [DATA_W-1:0] sat_p(input logic signed [PW-1:0] v);
    if (v[PW-1:DATA_W-1] == '0 || v[PW-1:DATA_W-1] == '1) return v[DATA_W-1:0];
    return v[PW-1] ? DMIN : DMAX;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_a(input logic signed [ACC_W:0] v);
    if (v[ACC_W] == v[ACC_W-1]) return v[ACC_W-1:0];
    return v[ACC_W] ? AMIN : AMAX;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_o(input logic signed [OW-1:0] v);
    if (v[OW-1:DATA_W-1] == '0 || v[OW-1:DATA_W-1] == '1) return v[DATA_W-1:0];
    return v[OW-1] ? DMIN : DMAX;
  endfunction

  state_t             state, state_d;
  logic [BIN_W-1:0]   bin_cnt;
  logic [SEG_W-1:0]   seg_cnt, nseg_q;
  logic [5:0]         shift_q;
  logic [1:0]         drain_cnt;
  logic [STAGES-1:0]  vld_pipe;
  s1_t                s1;
  s2_t                s2;

  logic signed [ACC_W-1:0] ram_r [NBIN];
  logic signed [ACC_W-1:0] ram_i [NBIN];

  logic in_fire, out_fire, last_bin, last_seg, load_first;
  logic [BIN_W-1:0] rd_idx;

  assign in_ready   = (state == ACCUM);
  assign busy       = (state != IDLE);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign last_bin   = (bin_cnt == BIN_W'(NBIN-1));
  assign last_seg   = (seg_cnt == nseg_q - SEG_W'(1));
  assign load_first = (state == DRAIN) && (drain_cnt == 2'd2) && !abort;
  assign rd_idx     = load_first ? '0 : out_bin + BIN_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; abort overrides everything, including start
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (in_fire && last_bin && last_seg) state_d = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_d = OUTPUT;
      OUTPUT:  if (out_fire && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Run configuration, bin/segment counters and drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      seg_cnt   <= '0;
      nseg_q    <= '0;
      shift_q   <= '0;
      drain_cnt <= '0;
    end else if (abort) begin
      bin_cnt   <= '0;
      seg_cnt   <= '0;
      nseg_q    <= '0;
      shift_q   <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == IDLE && start) begin
        nseg_q  <= (num_seg == '0) ? SEG_W'(1) : num_seg;
        shift_q <= out_shift;
        bin_cnt <= '0;
        seg_cnt <= '0;
      end else if (in_fire) begin
        bin_cnt <= last_bin ? '0 : bin_cnt + BIN_W'(1);
        if (last_bin) seg_cnt <= seg_cnt + SEG_W'(1);
      end
    end
  end

  // Stage-1 and stage-2 products (round half up, then arithmetic shift)
  logic signed [PW-1:0]     m1_r, m1_i, m2_r, m2_i;
  logic signed [DATA_W-1:0] t_r, t_i, c_r, c_i;

  // Complex multiplies feeding the two pipeline registers
  always_comb begin
    m1_r = PW'(f1_r) * PW'(f2_r) - PW'(f1_i) * PW'(f2_i) + RND;
    m1_i = PW'(f1_r) * PW'(f2_i) + PW'(f1_i) * PW'(f2_r) + RND;
    t_r  = $signed(s1.t.r);
    t_i  = $signed(s1.t.i);
    c_r  = $signed(s1.f3.r);
    // Negating the most negative value would wrap, so clamp it
    c_i  = ($signed(s1.f3.i) == DMIN) ? DMAX : -$signed(s1.f3.i);
    m2_r = PW'(t_r) * PW'(c_r) - PW'(t_i) * PW'(c_i) + RND;
    m2_i = PW'(t_i) * PW'(c_r) + PW'(t_r) * PW'(c_i) + RND;
  end

  // Pipeline registers and valid shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      vld_pipe    <= abort ? '0 : {vld_pipe[STAGES-2:0], in_fire};
      s1.t.r      <= sat_p(m1_r >>> FRAC_W);
      s1.t.i      <= sat_p(m1_i >>> FRAC_W);
      s1.f3.r     <= f3_r;
      s1.f3.i     <= f3_i;
      s1.bin      <= bin_cnt;
      s1.first    <= (seg_cnt == '0);
      s2.pr       <= ACC_W'(m2_r >>> FRAC_W);
      s2.pi       <= ACC_W'(m2_i >>> FRAC_W);
      s2.bin      <= s1.bin;
      s2.first    <= s1.first;
    end
  end

  // Accumulator update: first segment overwrites, later ones add with saturation
  logic signed [ACC_W:0] sum_r, sum_i;
  assign sum_r = (ACC_W+1)'(ram_r[s2.bin]) + (ACC_W+1)'($signed(s2.pr));
  assign sum_i = (ACC_W+1)'(ram_i[s2.bin]) + (ACC_W+1)'($signed(s2.pi));

  // Accumulator RAM write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (vld_pipe[1]) begin
      ram_r[s2.bin] <= s2.first ? $signed(s2.pr) : sat_a(sum_r);
      ram_i[s2.bin] <= s2.first ? $signed(s2.pi) : sat_a(sum_i);
    end
  end

  // Output scaling: rounded arithmetic right shift of the selected bin
  logic signed [OW-1:0] rnd_o, sc_r, sc_i;
  always_comb begin
    rnd_o = (shift_q == 6'd0) ? '0 : (OW'(1) <<< (shift_q - 6'd1));
    sc_r  = (OW'(ram_r[rd_idx]) + rnd_o) >>> shift_q;
    sc_i  = (OW'(ram_i[rd_idx]) + rnd_o) >>> shift_q;
  end

  // Output register: load bin 0 after drain, advance only on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_first) begin
        out_valid <= 1'b1;
        out_bin   <= '0;
        out_last  <= 1'b0;
        out_r     <= sat_o(sc_r);
        out_i     <= sat_o(sc_i);
      end else if (out_fire) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_r     <= '0;
          out_i     <= '0;
          out_bin   <= '0;
          out_last  <= 1'b0;
          done      <= 1'b1;
        end else begin
          out_bin   <= rd_idx;
          out_last  <= (rd_idx == BIN_W'(NBIN-1));
          out_r     <= sat_o(sc_r);
          out_i     <= sat_o(sc_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_bispectrum_accum_engine.sv
// Bench: randomized and directed runs checked against a complex-arithmetic
// reference model of the segment-averaged bispectrum.
module tb_bispectrum_accum_engine;
  localparam int DW = 16, FW = 14, AW = 40, NB = 4, SW = 8, BW = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [SW-1:0] num_seg = '0;
  logic [5:0] out_shift = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy, done;
  logic signed [DW-1:0] f1_r = '0, f1_i = '0, f2_r = '0, f2_i = '0, f3_r = '0, f3_i = '0;
  logic signed [DW-1:0] out_r, out_i;
  logic [BW-1:0] out_bin;

  bispectrum_accum_engine #(.DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .NBIN(NB), .SEG_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_seg(num_seg),
    .out_shift(out_shift), .in_valid(in_valid), .in_ready(in_ready),
    .f1_r(f1_r), .f1_i(f1_i), .f2_r(f2_r), .f2_i(f2_i), .f3_r(f3_r), .f3_i(f3_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_bin(out_bin), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  typedef struct { int f1r, f1i, f2r, f2i, f3r, f3i; } trip_t;

  // Reference arithmetic
  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) <<< (w-1)) - 1;
    longint mn = -mx - 1;
    return (v > mx) ? mx : (v < mn) ? mn : v;
  endfunction

  function automatic longint rsh(input longint v, input int s);
    if (s == 0) return v;
    return (v + (longint'(1) <<< (s-1))) >>> s;
  endfunction

  function automatic int rnd16();
    int k = $urandom_range(0, 9);
    if (k == 0) return -32768;
    if (k == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic trip_t make_trip(input int mode);
    trip_t t;
    case (mode)
      0: t = '{8192, 0, 8192, 0, 8192, 0};
      1: t = '{0, 16384, 0, 16384, 0, 16384};
      2: t = '{-32768, 0, -32768, 0, 16384, 0};
      3: t = '{16384, 0, 16384, 0, 0, -32768};
      default: t = '{rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16()};
    endcase
    return t;
  endfunction

  task automatic drive_trip(input trip_t t);
    f1_r = DW'(t.f1r); f1_i = DW'(t.f1i);
    f2_r = DW'(t.f2r); f2_i = DW'(t.f2i);
    f3_r = DW'(t.f3r); f3_i = DW'(t.f3i);
  endtask

  task automatic do_start(input int ns, input int sh);
    @(negedge clk);
    num_seg = SW'(ns); out_shift = 6'(sh); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic run(input int ns, input int sh, input int mode, input bit gaps,
                     input bit bp, input string nm);
    trip_t  stim[$];
    longint ar[NB], ai[NB], er[NB], ei[NB];
    int     neff = (ns == 0) ? 1 : ns;
    int     total = neff * NB;
    for (int k = 0; k < total; k++) begin
      trip_t  t = make_trip(mode);
      longint tr, ti, ci, pr, pi;
      int     b = k % NB;
      stim.push_back(t);
      tr = sat(rsh(longint'(t.f1r)*t.f2r - longint'(t.f1i)*t.f2i, FW), DW);
      ti = sat(rsh(longint'(t.f1r)*t.f2i + longint'(t.f1i)*t.f2r, FW), DW);
      ci = (t.f3i == -32768) ? 32767 : -t.f3i;
      pr = rsh(tr*t.f3r - ti*ci, FW);
      pi = rsh(ti*t.f3r + tr*ci, FW);
      if (k < NB) begin ar[b] = pr; ai[b] = pi; end
      else begin ar[b] = sat(ar[b] + pr, AW); ai[b] = sat(ai[b] + pi, AW); end
    end
    for (int b = 0; b < NB; b++) begin
      er[b] = sat(rsh(ar[b], sh), DW);
      ei[b] = sat(rsh(ai[b], sh), DW);
    end
    do_start(ns, sh);
    fork
      begin : driver
        int idx = 0, cyc = 0;
        while (idx < total && cyc < 3000) begin
          @(negedge clk); cyc++;
          in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          drive_trip(in_valid ? stim[idx] : make_trip(4));
          #4;
          if (in_valid && in_ready) idx++;
        end
        @(negedge clk); in_valid = 1'b0;
        chk({nm, "_in_count"}, idx, total);
      end
      begin : collector
        int got = 0, cyc = 0, stall = 0;
        bit stalled = 0, pend = 0;
        longint hr = 0, hi = 0, hb = 0;
        while (got < NB && cyc < 3000) begin
          @(negedge clk); cyc++;
          if (bp && !stalled && out_valid && out_bin == BW'(1)) begin stall = 5; stalled = 1; end
          if (stall > 0) begin out_ready = 1'b0; stall--; end
          else out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
          #4;
          if (pend) begin
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_r"}, out_r, hr);
            chk({nm, "_hold_i"}, out_i, hi);
            chk({nm, "_hold_bin"}, out_bin, hb);
          end
          if (out_valid) begin
            chk({nm, "_in_ready_out"}, in_ready, 0);
            if (out_ready) begin
              chk({nm, "_r"}, out_r, er[got]);
              chk({nm, "_i"}, out_i, ei[got]);
              chk({nm, "_bin"}, out_bin, got);
              chk({nm, "_last"}, out_last, (got == NB-1));
              got++; pend = 0;
            end else begin
              pend = 1; hr = out_r; hi = out_i; hb = out_bin;
            end
          end
        end
        out_ready = 1'b1;
        chk({nm, "_out_count"}, got, NB);
        if (got == NB) begin
          @(negedge clk); #4;
          chk({nm, "_done"}, done, 1);
          chk({nm, "_done_valid"}, out_valid, 0);
          chk({nm, "_done_busy"}, busy, 0);
          @(negedge clk); #4;
          chk({nm, "_done_once"}, done, 0);
        end else pulse_abort();
      end
    join
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); in_valid = 1'b1; drive_trip(make_trip(0));
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_last", out_last, 0);
    rst_n = 1'b1;

    run(1, 0, 0, 0, 0, "t1");
    run(4, 2, 0, 0, 0, "t2");
    run(0, 0, 0, 0, 0, "t2_zero");
    run(2, 0, 1, 0, 0, "t3");
    run(1, 0, 2, 0, 0, "t4a");
    run(1, 0, 3, 0, 0, "t4b");
    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 5), $urandom_range(0, 6), 4, 1, 1, "t5");
    run(8, 20, 4, 1, 1, "t5_bigshift");
    run(3, 0, 3, 1, 1, "t5_accsat");

    // abort together with start from IDLE: start must be ignored
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // abort mid-ACCUM
    do_start(2, 0);
    feed(5);
    @(negedge clk); abort = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;

    // abort while a result is being held
    out_ready = 1'b0;
    do_start(1, 0);
    feed(4);
    begin
      int w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      chk("abort_out_wait", out_valid, 1);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_clear_v", out_valid, 0);
    chk("abort_out_clear_r", out_r, 0);
    chk("abort_out_busy", busy, 0);
    @(negedge clk); abort = 1'b0; out_ready = 1'b1;

    // asynchronous reset mid-ACCUM
    do_start(3, 1);
    feed(3);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;

    run(1, 0, 0, 0, 0, "t6_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
